// File: rtl/controller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg
// Shared definitions for the multicycle RISC-V controller: FSM state
// encoding, opcode constants, ALU operation class (aluop) codes, the
// alucontrol encodings, and the immediate-format decode helper.
// ---------------------------------------------------------------------------
package controller_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format select; it depends only on the opcode so the
    // datapath sees a stable value in every state.
    function automatic logic [1:0] immsrcFor(input logic [6:0] op);
        case (op)
            OP_SW:   return 2'b01;
            OP_BEQ:  return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the ALU operation class plus instruction
// fields into the 3-bit alucontrol code.
// Ports:
//   aluop_i      class from the FSM: add / sub / decode-by-funct
//   funct3_i     instr[14:12]
//   opb5_i       instr[5], distinguishes R-type from I-type
//   funct7b5_i   instr[30]
//   alucontrol_o ALU operation
// ---------------------------------------------------------------------------
module alu_decoder
    import controller_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       opb5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type sub sets funct7b5; addi reuses that bit
                    // as part of its immediate, so opb5 gates it.
                    3'b000:  alucontrol_o = (opb5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol_o = ALU_SLT;
                    3'b110:  alucontrol_o = ALU_OR;
                    3'b111:  alucontrol_o = ALU_AND;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore FSM sequencing a multicycle RISC-V datapath (lw, sw, R-type,
// I-type ALU, beq, jal).
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   op, funct3, funct7b5 instruction fields
//   zero                ALU zero flag, used for beq
//   pcwrite, adrsrc, memwrite, irwrite, regwrite  datapath enables/selects
//   resultsrc, alusrca, alusrcb, immsrc           datapath mux selects
//   alucontrol          ALU operation
// ---------------------------------------------------------------------------
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 pcwrite,
    output logic                 adrsrc,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic [1:0]           resultsrc,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           immsrc,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    state_t     state_q;
    state_t     state_d;
    logic       pcupdate;
    logic       branch;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Moore outputs: everything here depends on state only.
    always_comb begin
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        aluop     = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            MEMREAD: adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTER: begin
                alusrca = 2'b10;
                aluop   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: regwrite = 1'b1;
            BEQ: begin
                alusrca = 2'b10;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Branch resolution is the only output that also looks at zero.
    assign pcwrite = pcupdate | (branch & zero);
    assign immsrc  = immsrcFor(op);

    alu_decoder u_alu_decoder (
        .aluop_i      (aluop),
        .funct3_i     (funct3),
        .opb5_i       (op[5]),
        .funct7b5_i   (funct7b5),
        .alucontrol_o (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for the multicycle controller. All outputs are packed into
// one 16-bit vector and compared against hand-written expectations:
//   {pcwrite, adrsrc, memwrite, irwrite, regwrite,
//    resultsrc, alusrca, alusrcb, immsrc, alucontrol}
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;

    int total;
    int bad;

    multicycle_controller #(.ALUCTRL_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .alucontrol (alucontrol)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a broken design cannot stall the run.
    initial begin
        #20000;
        $display("[TB] FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

    // Build an expected vector from readable fields.
    function automatic logic [15:0] mk(input logic [4:0] en, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] imm, input logic [2:0] alu);
        return {en, rs, a, b, imm, alu};
    endfunction

    // Drive instruction fields and let combinational outputs settle.
    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        #1;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the packed outputs with the expected vector.
    task automatic checkOutput(input string tag, input logic [15:0] expected);
        logic [15:0] observed;
        observed = {pcwrite, adrsrc, memwrite, irwrite, regwrite,
                    resultsrc, alusrca, alusrcb, immsrc, alucontrol};
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        op       = 7'b0000011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;

        // Reset while a load opcode is present.
        @(negedge clk);
        step();
        reset = 1'b0;
        checkOutput("reset_fetch", mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

        // lw: 5 cycles, regwrite only in MEMWB.
        step(); checkOutput("lw_decode",  mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        step(); checkOutput("lw_memadr",  mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
        step(); checkOutput("lw_memread", mk(5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        step(); checkOutput("lw_memwb",   mk(5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));
        step();
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        checkOutput("sw_fetch",    mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000));

        // sw: 4 cycles, memwrite only in MEMWRITE.
        step(); checkOutput("sw_decode",   mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000));
        step(); checkOutput("sw_memadr",   mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000));
        step(); checkOutput("sw_memwrite", mk(5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
        step();
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);
        checkOutput("r_sub_fetch", mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

        // R-type sub.
        step(); checkOutput("r_sub_decode", mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        step(); checkOutput("r_sub_exec",   mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001));
        step(); checkOutput("r_sub_aluwb",  mk(5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        step();
        applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0);
        checkOutput("r_add_fetch", mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

        // R-type add.
        step(); step();
        checkOutput("r_add_exec", mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000));
        step(); step();
        applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0);

        // R-type and.
        step(); step();
        checkOutput("r_and_exec", mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010));
        step(); step();
        applyStimulus(7'b0010011, 3'b110, 1'b1, 1'b0);

        // ori with funct7b5 set must not become sub-like.
        step(); step();
        checkOutput("i_or_exec",  mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011));
        step(); checkOutput("i_or_aluwb", mk(5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        step();
        applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0);

        // addi with funct7b5 set stays add.
        step(); step();
        checkOutput("i_add_exec", mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
        step(); step();
        applyStimulus(7'b0010011, 3'b010, 1'b0, 1'b0);

        // slti.
        step(); step();
        checkOutput("i_slt_exec", mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101));
        step(); step();
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);

        // beq taken: 3 cycles.
        checkOutput("beq_fetch", mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000));
        step(); checkOutput("beq_decode_zero", mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000));
        step(); checkOutput("beq_taken", mk(5'b10000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0);
        checkOutput("beq_zero_drop", mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
        step(); checkOutput("beq_back_fetch", mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000));

        // beq not taken.
        step(); step();
        checkOutput("beq_not_taken", mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
        step();
        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);

        // jal: 4 cycles.
        checkOutput("jal_fetch", mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000));
        step(); step();
        checkOutput("jal_jal",   mk(5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000));
        step(); checkOutput("jal_aluwb", mk(5'b00001, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000));
        step();
        applyStimulus(7'b1110011, 3'b000, 1'b0, 1'b0);

        // Unsupported opcode: FETCH, DECODE, back to FETCH.
        checkOutput("bad_fetch",  mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        step(); checkOutput("bad_decode", mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
        step(); checkOutput("bad_refetch", mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);

        // Reset during MEMREAD abandons the load.
        step(); step(); step();
        checkOutput("rst_mid_memread", mk(5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rst_mid_fetch",  mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
        step(); checkOutput("rst_mid_decode", mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3, width of alucontrol; only value 3 is supported.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  instruction opcode, instr[6:0].
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 pcwrite, adrsrc, memwrite, irwrite, regwrite  output  1 each  datapath enables/selects.
REQ-009 resultsrc, alusrca, alusrcb, immsrc  output  2 each  datapath mux selects.
REQ-010 alucontrol  output  ALUCTRL_W  ALU operation.

Function
REQ-011 The controller SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; state advances on every rising clk.
REQ-012 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (op 0000011 or 0100011), EXECUTER (0110011), EXECUTEI (0010011), BEQ (1100011), JAL (1101111), else FETCH; MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH; EXECUTER, EXECUTEI, JAL->ALUWB.
REQ-013 Per-state outputs (all unlisted outputs 0, aluop 00): FETCH adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, resultsrc=10, pcupdate=1; DECODE alusrca=01, alusrcb=01; MEMADR alusrca=10, alusrcb=01; MEMREAD adrsrc=1; MEMWB resultsrc=01, regwrite=1; MEMWRITE adrsrc=1, memwrite=1; EXECUTER alusrca=10, aluop=10; EXECUTEI alusrca=10, alusrcb=01, aluop=10; ALUWB regwrite=1; BEQ alusrca=10, aluop=01, branch=1; JAL alusrca=01, alusrcb=10, pcupdate=1.
REQ-014 pcwrite SHALL equal pcupdate OR (branch AND zero), combinational from state and zero, same cycle.
REQ-015 immsrc SHALL decode from op in every state: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-016 alucontrol SHALL be: aluop 00->000 (add); 01->001 (sub); 10 by funct3: 000->001 if op[5]&funct7b5 else 000, 010->101 (slt), 110->011 (or), 111->010 (and), other->000.
REQ-017 Unsupported opcodes SHALL cost exactly two cycles (FETCH, DECODE) with no regwrite/memwrite asserted.
REQ-018 Instruction latency SHALL be: lw 5, sw 4, R/I-ALU 4, beq 3, jal 4 cycles.
REQ-019 regwrite and memwrite SHALL never be asserted simultaneously.

Reset
REQ-020 While reset is high at a rising clk, the state SHALL become FETCH, including mid-instruction; outputs SHALL then be FETCH values.
REQ-021 No output SHALL depend on reset combinationally; reset acts only through the state register.

Structure
REQ-022 A shared package controller_pkg SHALL hold the state enum, opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL) and alucontrol encodings.
REQ-023 ALU decoding (REQ-016) SHALL be a separate combinational sub-module alu_decoder; state register and output decode remain in multicycle_controller.

Verification
REQ-024 reset=1 one clk with op=0000011 -> state FETCH, irwrite=1, pcwrite=1, alusrcb=10, resultsrc=10.
REQ-025 lw (op=0000011) from FETCH -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regwrite=1 only in cycle 5, resultsrc=01, then FETCH.
REQ-026 sw (op=0100011) -> memwrite=1 only in cycle 4, adrsrc=1, immsrc=01, regwrite never 1.
REQ-027 R-type op=0110011, funct3=000, funct7b5=1 -> EXECUTER alucontrol=001; funct7b5=0 -> 000; funct3=111 -> 010; ALUWB regwrite=1.
REQ-028 beq op=1100011 in BEQ: zero=1 -> pcwrite=1, alucontrol=001; zero=0 -> pcwrite=0; next state FETCH.
REQ-029 op=1110011 -> DECODE->FETCH, no writes; reset asserted during MEMREAD -> FETCH next clk, MEMWB never entered.
